// File: rtl/io_din_filter_if.sv
// Pad-input conditioning bus: raw pads and control in, conditioned bits and irq out.
interface io_din_filter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] io_din;
  logic [CNT_W-1:0] deb_len;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] flag_clr;
  logic [WIDTH-1:0] din_sync;
  logic [WIDTH-1:0] din_filt;
  logic [WIDTH-1:0] edge_flag;
  logic             irq;

  modport master (
    output io_din, deb_len, edge_sel, irq_en, flag_clr,
    input  din_sync, din_filt, edge_flag, irq
  );

  modport slave (
    input  io_din, deb_len, edge_sel, irq_en, flag_clr,
    output din_sync, din_filt, edge_flag, irq
  );
endinterface

// File: rtl/io_din_filter.sv
// Per-pad synchronizer, programmable debounce and sticky edge flags; one lane per bit.
module io_din_filter_lane #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_i,
  input  logic [CNT_W-1:0] deb_len_i,
  input  logic             edge_sel_i,
  input  logic             flag_clr_i,
  output logic             din_sync_o,
  output logic             din_filt_o,
  output logic             edge_flag_o
);
  logic             s1_q, s2_q;
  logic             filt_q, filt_d;
  logic             filt_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] lim;
  logic             evt;

  // deb_len of 0 qualifies like 1
  assign lim = (deb_len_i == '0) ? '0 : deb_len_i - CNT_W'(1);

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q >= lim) filt_d = s2_q;
      else              cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  assign evt = edge_sel_i ? (~filt_q & filt_dly_q) : (filt_q & ~filt_dly_q);

  // a detected edge beats a same-cycle clear
  always_comb begin
    flag_d = flag_q;
    if (flag_clr_i) flag_d = 1'b0;
    if (evt)        flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
    end else begin
      s1_q       <= din_i;
      s2_q       <= s1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
    end
  end

  assign din_sync_o  = s2_q;
  assign din_filt_o  = filt_q;
  assign edge_flag_o = flag_q;
endmodule

module io_din_filter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic          mclk,
  input  logic          puc_rst,
  io_din_filter_if.slave bus
);
  logic [WIDTH-1:0] sync_w, filt_w, flag_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    io_din_filter_lane #(.CNT_W(CNT_W)) u_lane (
      .clk         (mclk),
      .rst         (puc_rst),
      .din_i       (bus.io_din[i]),
      .deb_len_i   (bus.deb_len),
      .edge_sel_i  (bus.edge_sel[i]),
      .flag_clr_i  (bus.flag_clr[i]),
      .din_sync_o  (sync_w[i]),
      .din_filt_o  (filt_w[i]),
      .edge_flag_o (flag_w[i])
    );
  end

  assign bus.din_sync  = sync_w;
  assign bus.din_filt  = filt_w;
  assign bus.edge_flag = flag_w;
  // driven only from flag registers, so no pad glitch reaches irq
  assign bus.irq       = |(flag_w & bus.irq_en);
endmodule

// File: tb/tb_io_din_filter.sv
// Directed bench for io_din_filter: reset, latency, debounce, falling edge, set/clear, mid reset.
module tb_io_din_filter;
  logic mclk = 1'b0;
  logic puc_rst;
  int   checks = 0;
  int   failures = 0;

  io_din_filter_if #(.WIDTH(8), .CNT_W(4)) bus ();

  io_din_filter #(.WIDTH(8), .CNT_W(4)) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .bus     (bus.slave)
  );

  always #5 mclk = ~mclk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    puc_rst      = 1'b1;
    bus.io_din   = 8'hFF;
    bus.deb_len  = 4'd0;
    bus.edge_sel = 8'h00;
    bus.irq_en   = 8'h00;
    bus.flag_clr = 8'h00;

    // reset with pads held high
    tick(2);
    chk("rst_sync", bus.din_sync, 8'h00);
    chk("rst_filt", bus.din_filt, 8'h00);
    chk("rst_flag", bus.edge_flag, 8'h00);
    chk("rst_irq", bus.irq, 1'b0);
    puc_rst = 1'b0;
    tick();
    chk("rel_e1_sync", bus.din_sync, 8'h00);
    tick();
    chk("rel_e2_sync", bus.din_sync, 8'hFF);
    chk("rel_e2_filt", bus.din_filt, 8'h00);
    tick();
    chk("rel_e3_filt", bus.din_filt, 8'hFF);
    chk("rel_e3_flag", bus.edge_flag, 8'h00);
    tick();
    chk("rel_e4_flag", bus.edge_flag, 8'hFF);
    chk("rel_irq_off", bus.irq, 1'b0);
    bus.irq_en = 8'hFF;
    #1;
    chk("rel_irq_on", bus.irq, 1'b1);
    bus.flag_clr = 8'hFF;
    tick();
    bus.flag_clr = 8'h00;
    chk("rel_clr_flag", bus.edge_flag, 8'h00);
    chk("rel_clr_irq", bus.irq, 1'b0);

    // settle low; falling edges with rising select leave flags clear
    bus.io_din = 8'h00;
    tick(5);
    chk("low_filt", bus.din_filt, 8'h00);
    chk("low_flag", bus.edge_flag, 8'h00);

    // latency, deb_len=0, bit 3
    bus.irq_en = 8'h08;
    bus.io_din = 8'h08;
    tick();
    chk("lat_E_sync", bus.din_sync, 8'h00);
    tick();
    chk("lat_E1_sync", bus.din_sync, 8'h08);
    chk("lat_E1_filt", bus.din_filt, 8'h00);
    tick();
    chk("lat_E2_filt", bus.din_filt, 8'h08);
    chk("lat_E2_flag", bus.edge_flag, 8'h00);
    chk("lat_E2_irq", bus.irq, 1'b0);
    tick();
    chk("lat_E3_flag", bus.edge_flag, 8'h08);
    chk("lat_E3_irq", bus.irq, 1'b1);
    bus.irq_en = 8'h00;
    #1;
    chk("lat_irq_dis", bus.irq, 1'b0);
    bus.flag_clr = 8'h08;
    tick();
    bus.flag_clr = 8'h00;
    chk("lat_clr", bus.edge_flag, 8'h00);

    // debounce: 4-cycle glitch on bit 0 with deb_len=5 is rejected
    bus.deb_len = 4'd5;
    bus.io_din  = 8'h09;
    tick(4);
    bus.io_din  = 8'h08;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("deb_glitch_filt", bus.din_filt[0], 1'b0);
    end
    chk("deb_glitch_flag", bus.edge_flag[0], 1'b0);

    // debounce: held pulse qualifies 5 edges after din_sync rises
    bus.io_din = 8'h09;
    tick();
    chk("deb_E_sync", bus.din_sync[0], 1'b0);
    tick();
    chk("deb_E1_sync", bus.din_sync[0], 1'b1);
    tick(4);
    chk("deb_E5_filt", bus.din_filt[0], 1'b0);
    tick();
    chk("deb_E6_filt", bus.din_filt[0], 1'b1);
    chk("deb_E6_flag", bus.edge_flag[0], 1'b0);
    tick();
    chk("deb_E7_flag", bus.edge_flag[0], 1'b1);
    bus.flag_clr = 8'h01;
    tick();
    bus.flag_clr = 8'h00;
    chk("deb_clr", bus.edge_flag, 8'h00);

    // falling edge select on bit 1, deb_len=1
    bus.deb_len  = 4'd1;
    bus.edge_sel = 8'h02;
    bus.io_din   = 8'h0B;
    tick(5);
    chk("fall_rise_filt", bus.din_filt[1], 1'b1);
    chk("fall_rise_noflag", bus.edge_flag[1], 1'b0);
    bus.io_din = 8'h09;
    tick(3);
    chk("fall_E2_filt", bus.din_filt[1], 1'b0);
    chk("fall_E2_flag", bus.edge_flag[1], 1'b0);
    tick();
    chk("fall_E3_flag", bus.edge_flag[1], 1'b1);
    bus.flag_clr = 8'h02;
    tick();
    bus.flag_clr = 8'h00;
    chk("fall_clr", bus.edge_flag[1], 1'b0);

    // select change alone must not flag
    bus.edge_sel = 8'h00;
    tick(2);
    chk("sel_chg_noflag", bus.edge_flag, 8'h00);

    // set/clear collision on bit 2
    bus.deb_len = 4'd0;
    bus.io_din  = 8'h0D;
    tick(3);
    chk("coll_filt", bus.din_filt[2], 1'b1);
    bus.flag_clr = 8'h04;
    tick();
    bus.flag_clr = 8'h00;
    chk("coll_set_wins", bus.edge_flag[2], 1'b1);
    tick();
    chk("coll_hold", bus.edge_flag[2], 1'b1);
    bus.flag_clr = 8'h04;
    tick();
    bus.flag_clr = 8'h00;
    chk("coll_clr_alone", bus.edge_flag[2], 1'b0);

    // mid-debounce async reset on bit 4, deb_len=10
    bus.deb_len = 4'd10;
    bus.io_din  = 8'h1D;
    tick(2);
    chk("mid_sync", bus.din_sync[4], 1'b1);
    tick(6);
    chk("mid_pre_filt", bus.din_filt[4], 1'b0);
    puc_rst = 1'b1;
    #1;
    chk("mid_rst_sync", bus.din_sync, 8'h00);
    chk("mid_rst_filt", bus.din_filt, 8'h00);
    chk("mid_rst_flag", bus.edge_flag, 8'h00);
    chk("mid_rst_irq", bus.irq, 1'b0);
    tick();
    puc_rst = 1'b0;
    tick(2);
    chk("mid_rel_sync", bus.din_sync, 8'h1D);
    tick(9);
    chk("mid_rel_e11_filt", bus.din_filt, 8'h00);
    tick();
    chk("mid_rel_e12_filt", bus.din_filt, 8'h1D);
    chk("mid_rel_e12_flag", bus.edge_flag, 8'h00);
    bus.irq_en = 8'h10;
    tick();
    chk("mid_rel_e13_flag", bus.edge_flag, 8'h1D);
    chk("mid_rel_irq", bus.irq, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
